// File: rtl/f_fetch_unit_pkg.sv
// Shared constants and types for the F-stage fetch unit.
// FETCH_EXC_EN enables the AdEL fetch-address check.
package f_fetch_unit_pkg;

  localparam logic [31:0] PC_INIT  = 32'h0000_3000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_NONE = 5'd0;

  typedef enum logic {
    ST_BUBBLE = 1'b0,
    ST_VALID  = 1'b1
  } fd_state_e;

`ifdef FETCH_EXC_EN
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT = 32'h0000_6FFC;

  function automatic logic adel_chk(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
  endfunction
`endif

endpackage

// File: rtl/f_fetch_unit_fd_reg.sv
// F/D pipeline register {pc, instr, valid, exccode}.
// Exccode field exists only when FETCH_EXC_EN is defined.
module f_fetch_unit_fd_reg
  import f_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_valid
`ifdef FETCH_EXC_EN
  ,
  input  logic [4:0]  in_exccode,
  output logic [4:0]  out_exccode
`endif
);

  fd_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
`ifdef FETCH_EXC_EN
  logic [4:0]  exc_q, exc_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_EXC_EN
    exc_d   = exc_q;
`endif
    unique case (1'b1)
      flush: begin
        state_d = ST_BUBBLE;
        pc_d    = in_pc;
        instr_d = NOP;
`ifdef FETCH_EXC_EN
        exc_d   = EXC_NONE;
`endif
      end
      (!flush && !stall): begin
        state_d = ST_VALID;
        pc_d    = in_pc;
        instr_d = in_instr;
`ifdef FETCH_EXC_EN
        exc_d   = in_exccode;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BUBBLE;
      pc_q    <= 32'h0;
      instr_q <= NOP;
`ifdef FETCH_EXC_EN
      exc_q   <= EXC_NONE;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef FETCH_EXC_EN
      exc_q   <= exc_d;
`endif
    end
  end

  assign out_pc    = pc_q;
  assign out_instr = instr_q;
  assign out_valid = (state_q == ST_VALID);
`ifdef FETCH_EXC_EN
  assign out_exccode = exc_q;
`endif

endmodule

// File: rtl/f_fetch_unit.sv
// F-stage: fetch PC register, fetch counter and F/D register.
// Define FETCH_EXC_EN for AdEL address checking and D_exccode.
module f_fetch_unit
  import f_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] npc,
  output logic [31:0] F_pc,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic        D_valid,
  output logic [31:0] fetch_cnt
`ifdef FETCH_EXC_EN
  ,
  output logic [4:0]  D_exccode
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] f_instr;

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (!stall) pc_d = npc;
    if (!stall && !flush) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= PC_INIT;
      cnt_q <= 32'h0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef FETCH_EXC_EN
  logic       adel;
  logic [4:0] f_exc;

  // A faulting fetch enters decode as a valid nop carrying AdEL.
  assign adel    = adel_chk(pc_q);
  assign f_instr = adel ? NOP : i_inst_rdata;
  assign f_exc   = adel ? EXC_ADEL : EXC_NONE;
`else
  assign f_instr = i_inst_rdata;
`endif

  f_fetch_unit_fd_reg u_fd_reg (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .in_pc       (pc_q),
    .in_instr    (f_instr),
    .out_pc      (D_pc),
    .out_instr   (D_instr),
    .out_valid   (D_valid)
`ifdef FETCH_EXC_EN
    ,
    .in_exccode  (f_exc),
    .out_exccode (D_exccode)
`endif
  );

  assign F_pc        = pc_q;
  assign i_inst_addr = pc_q;
  assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_f_fetch_unit.sv
// Testbench for f_fetch_unit: directed vector table plus
// randomized traffic against a behavioural model.
module tb_f_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] npc, rdata;
  logic [31:0] F_pc, i_inst_addr, D_pc, D_instr, fetch_cnt;
  logic        D_valid;
`ifdef FETCH_EXC_EN
  logic [4:0]  D_exccode;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  f_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .npc          (npc),
    .F_pc         (F_pc),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (rdata),
    .D_pc         (D_pc),
    .D_instr      (D_instr),
    .D_valid      (D_valid),
    .fetch_cnt    (fetch_cnt)
`ifdef FETCH_EXC_EN
    ,
    .D_exccode    (D_exccode)
`endif
  );

  // Behavioural model state
  logic [31:0] m_pc, m_dpc, m_di, m_cnt;
  logic        m_dv;
  logic [4:0]  m_exc;

  function automatic logic bad_addr(input logic [31:0] a);
`ifdef FETCH_EXC_EN
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_pc = 32'h3000; m_dpc = 0; m_di = 0;
      m_dv = 0; m_cnt = 0; m_exc = 0;
    end else if (flush) begin
      m_dpc = m_pc; m_di = 0; m_dv = 0; m_exc = 0;
      if (!stall) m_pc = npc;
    end else if (!stall) begin
      m_dpc = m_pc;
      m_di  = bad_addr(m_pc) ? 32'h0 : rdata;
      m_exc = bad_addr(m_pc) ? 5'd4 : 5'd0;
      m_dv  = 1'b1;
      m_cnt = m_cnt + 1;
      m_pc  = npc;
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f,
                       input logic [31:0] n, input logic [31:0] d);
    reset = r; stall = s; flush = f; npc = n; rdata = d;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".F_pc"}, F_pc, m_pc);
    check({tag, ".addr"}, i_inst_addr, m_pc);
    check({tag, ".D_pc"}, D_pc, m_dpc);
    check({tag, ".D_instr"}, D_instr, m_di);
    check({tag, ".D_valid"}, {31'h0, D_valid}, {31'h0, m_dv});
    check({tag, ".cnt"}, fetch_cnt, m_cnt);
`ifdef FETCH_EXC_EN
    check({tag, ".exc"}, {27'h0, D_exccode}, {27'h0, m_exc});
`endif
  endtask

  typedef struct {
    logic        r, s, f;
    logic [31:0] n, d;
    logic [31:0] e_pc, e_dpc, e_di;
    logic        e_v;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // reset, stall, flush, npc, rdata | F_pc, D_pc, D_instr, D_valid, cnt
    tbl[0]  = '{1,0,0,32'h0,    32'h0,   32'h3000,32'h0,   32'h0,   0,0};
    tbl[1]  = '{1,0,0,32'h0,    32'h0,   32'h3000,32'h0,   32'h0,   0,0};
    tbl[2]  = '{0,0,0,32'h3004, 32'hA0,  32'h3004,32'h3000,32'hA0,  1,1};
    tbl[3]  = '{0,0,0,32'h3008, 32'hA1,  32'h3008,32'h3004,32'hA1,  1,2};
    tbl[4]  = '{0,0,0,32'h300C, 32'hA2,  32'h300C,32'h3008,32'hA2,  1,3};
    tbl[5]  = '{0,0,0,32'h3010, 32'hA3,  32'h3010,32'h300C,32'hA3,  1,4};
    tbl[6]  = '{0,1,0,32'h4000, 32'hB0,  32'h3010,32'h300C,32'hA3,  1,4};
    tbl[7]  = '{0,1,0,32'h4000, 32'hB0,  32'h3010,32'h300C,32'hA3,  1,4};
    tbl[8]  = '{0,1,0,32'h4000, 32'hB0,  32'h3010,32'h300C,32'hA3,  1,4};
    tbl[9]  = '{0,0,0,32'h4000, 32'hB0,  32'h4000,32'h3010,32'hB0,  1,5};
    tbl[10] = '{0,0,0,32'h3020, 32'hB1,  32'h3020,32'h4000,32'hB1,  1,6};
    tbl[11] = '{0,1,1,32'h5000, 32'hB2,  32'h3020,32'h3020,32'h0,   0,6};
    tbl[12] = '{0,0,0,32'h3040, 32'hC0,  32'h3040,32'h3020,32'hC0,  1,7};
    tbl[13] = '{0,0,0,32'h3100, 32'h12345678,
                                         32'h3100,32'h3040,32'h12345678,1,8};
    tbl[14] = '{0,0,1,32'h3200, 32'hC1,  32'h3200,32'h3100,32'h0,   0,8};
    tbl[15] = '{1,1,0,32'h3204, 32'hC2,  32'h3000,32'h0,   32'h0,   0,0};
    tbl[16] = '{0,0,0,32'h3004, 32'hD0,  32'h3004,32'h3000,32'hD0,  1,1};

    reset = 1; stall = 0; flush = 0; npc = 0; rdata = 0;
    m_pc = 0; m_dpc = 0; m_di = 0; m_dv = 0; m_cnt = 0; m_exc = 0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].n, tbl[i].d);
      check($sformatf("v%0d.F_pc", i), F_pc, tbl[i].e_pc);
      check($sformatf("v%0d.addr", i), i_inst_addr, tbl[i].e_pc);
      check($sformatf("v%0d.D_pc", i), D_pc, tbl[i].e_dpc);
      check($sformatf("v%0d.D_instr", i), D_instr, tbl[i].e_di);
      check($sformatf("v%0d.D_valid", i), {31'h0, D_valid},
            {31'h0, tbl[i].e_v});
      check($sformatf("v%0d.cnt", i), fetch_cnt, tbl[i].e_cnt);
    end

`ifdef FETCH_EXC_EN
    // Misaligned then out-of-range fetch addresses raise AdEL.
    drive(0, 0, 0, 32'h3002, 32'hE0);
    check("adel0.exc", {27'h0, D_exccode}, 32'd0);
    drive(0, 0, 0, 32'h7000, 32'hE1);
    check("adel1.exc", {27'h0, D_exccode}, 32'd4);
    check("adel1.instr", D_instr, 32'h0);
    check("adel1.valid", {31'h0, D_valid}, 32'd1);
    check("adel1.dpc", D_pc, 32'h3002);
    drive(0, 0, 0, 32'h3000, 32'hE2);
    check("adel2.exc", {27'h0, D_exccode}, 32'd4);
    check("adel2.instr", D_instr, 32'h0);
    check("adel2.valid", {31'h0, D_valid}, 32'd1);
    drive(0, 1, 1, 32'h3000, 32'hE3);
    check("adel3.exc", {27'h0, D_exccode}, 32'd0);
    drive(0, 0, 0, 32'h3004, 32'hE4);
    check_model("adel4");
`endif

    for (int i = 0; i < 400; i++) begin
      logic        r, s, f;
      logic [31:0] n;
      r = ($urandom_range(0, 29) == 0);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 5))
        0:       n = 32'h3000 + ($urandom_range(0, 32'h0FFF) << 2);
        1:       n = $urandom;
        2:       n = 32'h6FFC + ($urandom_range(0, 2) << 2);
        default: n = m_pc + 32'd4;
      endcase
      drive(r, s, f, n, $urandom);
      check_model($sformatf("r%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
